// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-master round-robin arbiter in front of the SoC address mapper.
// Master 0 is the CPU, master 1 a secondary master (DMA / debug loader).
// The grant is locked for the whole transaction. An idle or losing master
// always sees ready/spo/fault = 0, whatever the mapper drives.
//
// Optional feature: define BUS_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT_CYCLES cycles without s_ready. The abort returns TIMEOUT_DATA with a
// ready and pulses timeout_err.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m0_a/d/we/rd               master 0 request (address, wdata, write, read)
//   m0_spo/ready/fault         master 0 response (rdata, done, unmapped)
//   m1_*                       same as master 0, for master 1
//   s_a/d/we/rd                forwarded request to the mapper
//   s_spo/ready/irq            mapper response (rdata, ready, unmapped flag)
//   timeout_err                one-cycle pulse on a timeout abort
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  output logic        m0_fault,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic        m1_fault,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  input  logic        s_irq,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rr_last, w_rr_nxt;
  logic        w_req0, w_req1;
  logic        w_sel, w_req_g, w_we_g;
  logic [31:0] w_spo_g;
  logic        w_rdy_g, w_flt_g;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] r_tcnt, w_tcnt_nxt;
  logic           w_tmo;
`else
  logic w_unused_params;
  assign w_unused_params = ^{TIMEOUT_DATA, 32'(TIMEOUT_CYCLES)};
`endif

  assign w_req0 = m0_rd | m0_we;
  assign w_req1 = m1_rd | m1_we;

  // State, round-robin pointer and timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      r_tcnt    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_nxt;
`ifdef BUS_TIMEOUT_EN
      r_tcnt    <= w_tcnt_nxt;
`endif
    end
  end

  // Next state, slave-side forwarding and granted-master response
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_last;
    w_sel       = 1'b0;
    w_req_g     = 1'b0;
    w_we_g      = 1'b0;
    w_spo_g     = '0;
    w_rdy_g     = 1'b0;
    w_flt_g     = 1'b0;
    s_a         = '0;
    s_d         = '0;
    s_we        = 1'b0;
    s_rd        = 1'b0;
    m0_spo      = '0;
    m0_ready    = 1'b0;
    m0_fault    = 1'b0;
    m1_spo      = '0;
    m1_ready    = 1'b0;
    m1_fault    = 1'b0;
    timeout_err = 1'b0;
`ifdef BUS_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
    w_tmo       = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) && !s_ready;
`endif

    case (r_state)
      IDLE: begin
`ifdef BUS_TIMEOUT_EN
        w_tcnt_nxt = '0;
`endif
        // On contention the master not served last wins
        if (w_req0 && w_req1)  w_state_nxt = r_rr_last ? BUSY0 : BUSY1;
        else if (w_req0)       w_state_nxt = BUSY0;
        else if (w_req1)       w_state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        w_sel   = (r_state == BUSY1);
        w_req_g = w_sel ? w_req1 : w_req0;
        w_we_g  = w_sel ? m1_we : m0_we;
        s_a     = w_sel ? m1_a : m0_a;
        s_d     = w_sel ? m1_d : m0_d;
        s_we    = w_we_g;
        // rd together with we is treated as a write
        s_rd    = (w_sel ? m1_rd : m0_rd) & ~w_we_g;
        w_spo_g = s_spo;
        w_flt_g = s_irq;
        if (!w_req_g) begin
          // Withdrawn request: back to IDLE, no ready, pointer untouched
          w_state_nxt = IDLE;
        end else if (s_ready) begin
          w_rdy_g     = 1'b1;
          w_state_nxt = IDLE;
          w_rr_nxt    = w_sel;
`ifdef BUS_TIMEOUT_EN
        end else if (w_tmo) begin
          w_rdy_g     = 1'b1;
          w_spo_g     = TIMEOUT_DATA;
          s_we        = 1'b0;
          s_rd        = 1'b0;
          timeout_err = 1'b1;
          w_state_nxt = IDLE;
          w_rr_nxt    = w_sel;
        end else begin
          w_tcnt_nxt = r_tcnt + TCW'(1);
`endif
        end
        if (w_sel) begin
          m1_spo   = w_spo_g;
          m1_ready = w_rdy_g;
          m1_fault = w_flt_g;
        end else begin
          m0_spo   = w_spo_g;
          m0_ready = w_rdy_g;
          m0_fault = w_flt_g;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: directed self-checking bench for bus_arbiter2.
// Inputs change 1 time unit after a rising edge; outputs are checked
// mid-cycle once the combinational paths have settled.
module tb_bus_arbiter2;

  localparam logic [31:0] A0 = 32'h10000010;
  localparam logic [31:0] A1 = 32'h20000020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_a, m0_d, m1_a, m1_d;
  logic        m0_we, m0_rd, m1_we, m1_rd;
  logic [31:0] m0_spo, m1_spo;
  logic        m0_ready, m0_fault, m1_ready, m1_fault;
  logic [31:0] s_a, s_d, s_spo;
  logic        s_we, s_rd, s_ready, s_irq;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_arbiter2 #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_spo(m0_spo), .m0_ready(m0_ready), .m0_fault(m0_fault),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_spo(m1_spo), .m1_ready(m1_ready), .m1_fault(m1_fault),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
    .s_spo(s_spo), .s_ready(s_ready), .s_irq(s_irq),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // All DUT outputs packed into one word; zero means fully quiet
  function automatic logic [31:0] outs_or();
    return s_a | s_d | m0_spo | m1_spo |
           32'({s_we, s_rd, m0_ready, m0_fault, m1_ready, m1_fault, timeout_err});
  endfunction

  initial begin
    rst_n = 1'b0;
    m0_a = '0; m0_d = '0; m0_we = 1'b0; m0_rd = 1'b0;
    m1_a = '0; m1_d = '0; m1_we = 1'b0; m1_rd = 1'b0;
    s_spo = '0; s_ready = 1'b0; s_irq = 1'b0;

    // Reset state
    step(); step(); settle();
    check("reset_outs", outs_or(), 32'd0);
    rst_n = 1'b1;

    // Single read, slave ready immediately
    step();
    m0_rd = 1'b1; m0_a = A0; s_ready = 1'b1; s_spo = 32'h12345678;
    settle();
    check("rd_idle_s_rd", 32'(s_rd), 32'd0);
    check("rd_idle_m0_ready", 32'(m0_ready), 32'd0);
    step(); settle();
    check("rd_s_rd", 32'(s_rd), 32'd1);
    check("rd_s_a", s_a, A0);
    check("rd_m0_ready", 32'(m0_ready), 32'd1);
    check("rd_m0_spo", m0_spo, 32'h12345678);
    check("rd_m1_ready", 32'(m1_ready), 32'd0);
    step();
    m0_rd = 1'b0;
    settle();
    check("rd_back_idle", outs_or(), 32'd0);

    // Contention from reset: grants alternate 0,1,0,1...
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1; m0_rd = 1'b1; m0_a = A0; m1_rd = 1'b1; m1_a = A1;
    s_ready = 1'b1; s_spo = 32'h0000abcd;
    for (int t = 0; t < 8; t++) begin
      settle();
      check("cont_idle", 32'({m0_ready, m1_ready, s_rd}), 32'd0);
      step(); settle();
      check("cont_m0_ready", 32'(m0_ready), 32'(t % 2 == 0));
      check("cont_m1_ready", 32'(m1_ready), 32'(t % 2 == 1));
      check("cont_s_a", s_a, (t % 2 == 0) ? A0 : A1);
      step();
    end
    m0_rd = 1'b0; m1_rd = 1'b0;
    step();

    // Wait states on a master 1 write; master 0 arrives mid-transaction
    m1_we = 1'b1; m1_d = 32'hcafef00d; m1_a = A1; s_ready = 1'b0;
    settle();
    check("ws_idle_s_we", 32'(s_we), 32'd0);
    step();
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin m0_rd = 1'b1; m0_a = A0; end
      if (k == 6) s_ready = 1'b1;
      settle();
      check("ws_s_we", 32'(s_we), 32'd1);
      check("ws_s_d", s_d, 32'hcafef00d);
      check("ws_m1_ready", 32'(m1_ready), 32'(k == 6));
      check("ws_m0_ready", 32'(m0_ready), 32'd0);
      step();
    end
    m1_we = 1'b0;
    settle();
    check("ws_gap_idle", 32'({s_we, s_rd, m0_ready}), 32'd0);
    step(); settle();
    check("ws_m0_s_rd", 32'(s_rd), 32'd1);
    check("ws_m0_s_a", s_a, A0);
    check("ws_m0_ready", 32'(m0_ready), 32'd1);
    step();
    m0_rd = 1'b0;
    step();

    // Fault passthrough only while granted
    m0_rd = 1'b1; m0_a = 32'hd0000000; s_irq = 1'b1; s_ready = 1'b1;
    settle();
    check("flt_idle_m0_fault", 32'(m0_fault), 32'd0);
    step(); settle();
    check("flt_m0_fault", 32'(m0_fault), 32'd1);
    check("flt_m0_ready", 32'(m0_ready), 32'd1);
    check("flt_m1_fault", 32'(m1_fault), 32'd0);
    step();
    m0_rd = 1'b0; s_irq = 1'b0; s_ready = 1'b0;
    step();

    // Reset during BUSY1 with the slave stalled
    m1_we = 1'b1; m1_a = A1; m1_d = 32'h55aa55aa;
    step(); settle();
    check("rst_busy1_s_we", 32'(s_we), 32'd1);
    step();
    rst_n = 1'b0;
    step(); settle();
    check("rst_mid_outs", outs_or(), 32'd0);
    rst_n = 1'b1; m0_rd = 1'b1; m0_a = A0;
    step(); settle();
    check("rst_after_s_rd", 32'(s_rd), 32'd1);
    check("rst_after_s_we", 32'(s_we), 32'd0);
    check("rst_after_s_a", s_a, A0);
    check("rst_after_m1_ready", 32'(m1_ready), 32'd0);
    s_ready = 1'b1;
    settle();
    check("rst_after_m0_ready", 32'(m0_ready), 32'd1);
    step();
    m0_rd = 1'b0;
    step(); settle();
    check("rst_after_m1_served", 32'(m1_ready), 32'd1);
    step();
    m1_we = 1'b0; s_ready = 1'b0;
    step();

    // Timeout with slave stuck not-ready
    m0_rd = 1'b1; m0_a = A0; s_spo = 32'h0;
    step();
`ifdef BUS_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      settle();
      check("tmo_m0_ready", 32'(m0_ready), 32'(k == 16));
      check("tmo_err", 32'(timeout_err), 32'(k == 16));
      if (k == 16) begin
        check("tmo_m0_spo", m0_spo, 32'hdeadbeef);
        check("tmo_s_rd", 32'(s_rd), 32'd0);
      end
      step();
    end
    m0_rd = 1'b0;
    settle();
    check("tmo_after_err", 32'(timeout_err), 32'd0);
    check("tmo_after_idle", outs_or(), 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      settle();
      if (k == 16 || k == 100) begin
        check("notmo_m0_ready", 32'(m0_ready), 32'd0);
        check("notmo_s_rd", 32'(s_rd), 32'd1);
        check("notmo_err", 32'(timeout_err), 32'd0);
      end
      step();
    end
    s_ready = 1'b1;
    settle();
    check("notmo_release", 32'(m0_ready), 32'd1);
    step();
    m0_rd = 1'b0; s_ready = 1'b0;
    settle();
    check("notmo_after_idle", outs_or(), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master round-robin arbiter directly upstream of the SoC address mapper (bus switch).
- Master 0 is the CPU. Master 1 is a secondary bus master (DMA / debug loader).
- Forwards exactly one master's request onto the single slave-side bus, returns read data and ready, and locks the grant for the whole transaction.
- Gates ready so an idle or losing master never sees the mapper's default ready=1.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in a BUSY state without s_ready before abort (used only with BUS_TIMEOUT_EN).
- TIMEOUT_DATA, 32'hdeadbeef: read data returned on timeout abort.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- m0_a  in  32  master 0 address
- m0_d  in  32  master 0 write data
- m0_we  in  1  master 0 write request
- m0_rd  in  1  master 0 read request
- m0_spo  out  32  master 0 read data
- m0_ready  out  1  master 0 transaction complete
- m0_fault  out  1  master 0 address fault (unmapped)
- m1_a, m1_d, m1_we, m1_rd, m1_spo, m1_ready, m1_fault: same as master 0, for master 1
- s_a  out  32  slave-side address to mapper
- s_d  out  32  slave-side write data
- s_we  out  1  slave-side write strobe
- s_rd  out  1  slave-side read strobe
- s_spo  in  32  mapper read data
- s_ready  in  1  mapper ready
- s_irq  in  1  mapper unmapped-address flag
- timeout_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Bus protocol, both sides:
  - A master raises rd or we with a, d stable.
  - It holds them until it samples its ready=1 at a rising edge.
  - rd and we are never both 1; if both are, the arbiter treats the cycle as a write.
- States: IDLE, BUSY0, BUSY1, plus registered rr_last (last-served master, reset 1 so master 0 wins first).
- IDLE:
  - All s_* outputs 0. All m*_ready, m*_spo, m*_fault are 0.
  - req0 = m0_rd|m0_we; req1 = m1_rd|m1_we.
  - Only req0: next state BUSY0. Only req1: next state BUSY1.
  - Both: grant the master that is not rr_last.
  - Neither: stay in IDLE.
- BUSYx:
  - s_a, s_d, s_we, s_rd = master x inputs (combinational).
  - mx_spo = s_spo; mx_ready = s_ready; mx_fault = s_irq.
  - The other master sees ready=0, spo=0, fault=0.
- Completion:
  - In BUSYx, if (mx_rd|mx_we) & s_ready at a clock edge: next state IDLE and rr_last <= x.
  - Minimum throughput is one transaction per 2 cycles: 1 arbitration cycle + 1 cycle if the slave is ready immediately.
- Request withdrawn: in BUSYx with mx_rd=mx_we=0, go to IDLE next cycle. rr_last is not updated and no ready is issued.
- Fault: s_irq is passed through only while granted. The arbiter does not abort on it; completion is still governed by s_ready.
- Latency: a request seen in IDLE at edge N drives the slave bus during cycle N+1. With s_ready=1, the master sees ready in cycle N+1.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1…; neither master starves.
- Reset:
  - rst_n=0 at any edge, including mid-BUSY, forces IDLE, rr_last=1, timeout counter 0, timeout_err=0.
  - All outputs read 0 in the following cycle.
  - An in-flight transaction is dropped without a ready.
- Output reset values: all s_*, m*_*, and timeout_err are 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSYx and increments each BUSY cycle without s_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ready=0: mx_ready=1 and mx_spo=TIMEOUT_DATA for that cycle, s_rd/s_we forced 0, timeout_err=1 for one cycle.
  - Next state is IDLE and rr_last <= x.
  - If s_ready=1 in the same cycle, normal completion wins and there is no timeout_err.
- Undefined: no counter; BUSY waits for s_ready indefinitely; timeout_err tied to 0.

Test Plan:
- Single read: m0_rd=1, m0_a=32'h10000010, slave s_ready=1 with s_spo=32'h12345678 → s_rd=1 and s_a=32'h10000010 one cycle after the request, m0_ready=1 with m0_spo=32'h12345678 that cycle, IDLE next.
- Contention: m0 and m1 both request continuously from reset, slave always ready → grant order 0,1,0,1 over 8 transactions, never two consecutive to the same master, m1 sees ready=0 while m0 is served.
- Wait states: m1_we=1, m1_d=32'hcafef00d, s_ready low 5 cycles then high → s_we held 6 cycles with stable s_d; m1_ready=1 only in the 6th cycle; m0 request arriving meanwhile is held until the following IDLE.
- Fault passthrough: m0_rd to 32'hd0000000, mapper drives s_irq=1, s_ready=1 → m0_fault=1 and m0_ready=1 the same cycle, m1_fault=0.
- Reset mid-transaction: rst_n=0 during BUSY1 with s_ready=0 → next cycle all outputs 0, state IDLE; after release, a simultaneous request is granted to m0.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): m0_rd with s_ready stuck 0 → m0_ready=1, m0_spo=32'hdeadbeef, timeout_err one-cycle pulse in the 16th BUSY cycle; without the macro, still waiting at cycle 100.
